// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int MEM_DEPTH  = 512;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// MAR/MDR owner and access sequencer for the 512x32 synchronous RAM.
// Optional macro MEM_CTRL_WAIT_EN inserts WAIT_CYCLES hold edges between ISSUE and CAPTURE.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_wait_range
        $error("mem_access_ctrl: WAIT_CYCLES must be 1..15");
    end

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   mar;
    logic [DATA_W-1:0]   mdr;
    logic [DATA_W-1:0]   rdata;
    logic                we_q;

`ifdef MEM_CTRL_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];
    logic [3:0] wait_cnt;

    // Loaded in ISSUE so the first WAIT edge sees the full count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = ISSUE;
`ifdef MEM_CTRL_WAIT_EN
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_cnt <= 4'd1) next_state = CAPTURE;
`else
            ISSUE:   next_state = CAPTURE;
`endif
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // rdata is kept apart from MDR so a write does not disturb the last read result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mar   <= '0;
            mdr   <= '0;
            rdata <= '0;
            we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mar  <= addr_in;
                        we_q <= we;
                        if (we) begin
                            mdr <= wdata_in;
                        end
                    end
                end
                CAPTURE: begin
                    if (!we_q) begin
                        mdr   <= mem_dout;
                        rdata <= mem_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign done      = (state == DONE);
    assign mem_write = (state == ISSUE) && we_q;
    assign mem_addr  = mar;
    assign mem_din   = mdr;
    assign rdata_out = rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a behavioural RAM as the load.
// Honours MEM_CTRL_WAIT_EN for the expected access latency.
module tb_mem_access_ctrl;

    localparam int TB_WAIT = 3;
`ifdef MEM_CTRL_WAIT_EN
    localparam int EXP_LAT = 3 + TB_WAIT;
`else
    localparam int EXP_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        req;
    logic        we;
    logic [8:0]  addr_in;
    logic [31:0] wdata_in;
    logic        ready;
    logic        done;
    logic [31:0] rdata_out;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [512];
    logic [31:0] last_read;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W     (9),
        .DATA_W     (32),
        .WAIT_CYCLES(TB_WAIT)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .we       (we),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .ready    (ready),
        .done     (done),
        .rdata_out(rdata_out),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00010001;
    endfunction

    // Downstream RAM: registered read, new data on read-during-write.
    logic [31:0] ram [512];
    bit          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_write) begin
            ram[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
        end else begin
            mem_dout <= ram[mem_addr];
        end
    end

    // Performs one access starting at a negedge; returns observations only.
    task automatic run_access(input logic w, input logic [8:0] a, input logic [31:0] d,
                              input bit hold, output int lat, output int wr_cnt,
                              output bit addr_ok, output logic [31:0] rd,
                              output int idle_wait, output bit timeout);
        timeout = 1'b0; idle_wait = 0; lat = 0; wr_cnt = 0; addr_ok = 1'b1; rd = '0;
        while (!ready && idle_wait < 50) begin
            @(negedge clk);
            idle_wait++;
        end
        if (!ready) begin
            timeout = 1'b1;
            return;
        end
        req = 1'b1; we = w; addr_in = a; wdata_in = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) req = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (mem_write) wr_cnt++;
            if (mem_addr !== a) addr_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!done) timeout = 1'b1;
        rd = rdata_out;
    endtask

    task automatic test_reset();
        int n;
        clr = 1'b0; req = 1'b1; we = 1'b0; addr_in = 9'h0A3; wdata_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
        checks++; if (rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_out); end
        checks++; if (mem_addr !== 9'h0) begin errors++; $display("FAIL reset_mar: got %h expected 0", mem_addr); end
        clr = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks++; if (ready !== 1'b0 || mem_addr !== 9'h0A3) begin
            errors++; $display("FAIL reset_first_accept: ready=%b mar=%h expected ready=0 mar=0a3", ready, mem_addr);
        end
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        checks++; if (rdata_out !== model_mem[9'h0A3]) begin
            errors++; $display("FAIL reset_first_read: got %h expected %h", rdata_out, model_mem[9'h0A3]);
        end
        last_read = model_mem[9'h0A3];
    endtask

    task automatic test_write_read();
        int lat, wc, iw; bit aok, to; logic [31:0] rd;
        run_access(1'b1, 9'h0A3, 32'hDEADBEEF, 1'b0, lat, wc, aok, rd, iw, to);
        model_mem[9'h0A3] = 32'hDEADBEEF;
        checks++; if (to) begin errors++; $display("FAIL wr_timeout: got timeout expected done"); end
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (wc != 1) begin errors++; $display("FAIL wr_mem_write_count: got %0d expected 1", wc); end
        checks++; if (!aok) begin errors++; $display("FAIL wr_mar_stable: got unstable expected stable"); end
        checks++; if (rd !== last_read) begin errors++; $display("FAIL wr_rdata_held: got %h expected %h", rd, last_read); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL done_one_cycle: done=%b ready=%b expected done=0 ready=1", done, ready);
        end
        run_access(1'b0, 9'h0A3, 32'h0, 1'b0, lat, wc, aok, rd, iw, to);
        checks++; if (to) begin errors++; $display("FAIL rd_timeout: got timeout expected done"); end
        checks++; if (lat != EXP_LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, EXP_LAT); end
        checks++; if (wc != 0) begin errors++; $display("FAIL rd_mem_write_count: got %0d expected 0", wc); end
        checks++; if (!aok) begin errors++; $display("FAIL rd_mar_stable: got unstable expected stable"); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
        last_read = rd;
    endtask

    task automatic test_boundary();
        int lat, wc, iw; bit aok, to; logic [31:0] rd;
        logic [8:0] addrs [3] = '{9'h1FF, 9'h000, 9'h1FE};
        run_access(1'b1, 9'h1FF, 32'h00000001, 1'b0, lat, wc, aok, rd, iw, to);
        model_mem[9'h1FF] = 32'h00000001;
        run_access(1'b1, 9'h000, 32'hFFFFFFFF, 1'b0, lat, wc, aok, rd, iw, to);
        model_mem[9'h000] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            run_access(1'b0, addrs[i], 32'h0, 1'b0, lat, wc, aok, rd, iw, to);
            checks++; if (to || rd !== model_mem[addrs[i]]) begin
                errors++; $display("FAIL boundary_read_%h: got %h expected %h", addrs[i], rd, model_mem[addrs[i]]);
            end
            last_read = model_mem[addrs[i]];
        end
    endtask

    task automatic test_busy_ignore();
        int n, done_cnt, wr_cnt, lat, wc, iw; bit aok, to; logic [31:0] rd, rd_first;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        req = 1'b1; we = 1'b0; addr_in = 9'h020; wdata_in = '0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr_in = 9'h010; wdata_in = 32'hBADBAD00;
        @(negedge clk);
        req = 1'b0;
        done_cnt = 0; wr_cnt = 0; rd_first = '0;
        repeat (14) begin
            @(negedge clk);
            if (mem_write) wr_cnt++;
            if (done) begin done_cnt++; rd_first = rdata_out; end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", done_cnt); end
        checks++; if (wr_cnt != 0) begin errors++; $display("FAIL busy_mem_write: got %0d expected 0", wr_cnt); end
        checks++; if (rd_first !== model_mem[9'h020]) begin
            errors++; $display("FAIL busy_read_data: got %h expected %h", rd_first, model_mem[9'h020]);
        end
        run_access(1'b0, 9'h010, 32'h0, 1'b0, lat, wc, aok, rd, iw, to);
        checks++; if (to || rd !== model_mem[9'h010]) begin
            errors++; $display("FAIL busy_no_write: got %h expected %h", rd, model_mem[9'h010]);
        end
        last_read = model_mem[9'h010];
    endtask

    task automatic test_reset_mid_write();
        int n, lat, wc, iw; bit aok, to; logic [31:0] rd;
        n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        req = 1'b1; we = 1'b1; addr_in = 9'h050; wdata_in = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL midrst_in_issue: got %b expected 1", mem_write); end
        #2 clr = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || done !== 1'b0 || mem_write !== 1'b0) begin
            errors++; $display("FAIL midrst_abort: ready=%b done=%b mem_write=%b expected 1 0 0", ready, done, mem_write);
        end
        checks++; if (mem_addr !== 9'h0 || rdata_out !== 32'h0) begin
            errors++; $display("FAIL midrst_regs: mar=%h rdata=%h expected 0 0", mem_addr, rdata_out);
        end
        @(negedge clk);
        clr = 1'b1;
        last_read = '0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got ready=%b expected 1", ready); end
        run_access(1'b0, 9'h050, 32'h0, 1'b0, lat, wc, aok, rd, iw, to);
        checks++; if (to || rd !== model_mem[9'h050]) begin
            errors++; $display("FAIL midrst_prior_data: got %h expected %h", rd, model_mem[9'h050]);
        end
        last_read = model_mem[9'h050];
    endtask

    task automatic test_random();
        int lat, wc, iw; bit aok, to; logic [31:0] rd, d; logic [8:0] a; logic w;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 9'($urandom_range(0, 511));
            d = $urandom;
            run_access(w, a, d, 1'b0, lat, wc, aok, rd, iw, to);
            checks++; if (to || lat != EXP_LAT || !aok || wc != (w ? 1 : 0)) begin
                errors++; $display("FAIL rand_timing_%0d: lat=%0d wr=%0d mar_ok=%b expected lat=%0d wr=%0d mar_ok=1",
                                   i, lat, wc, aok, EXP_LAT, w ? 1 : 0);
            end
            if (w) begin
                model_mem[a] = d;
            end else begin
                last_read = model_mem[a];
            end
            checks++; if (rd !== last_read) begin
                errors++; $display("FAIL rand_data_%0d: we=%b addr=%h got %h expected %h", i, w, a, rd, last_read);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, wc, iw; bit aok, to; logic [31:0] rd, d; logic [8:0] a; logic w;
        for (int i = 0; i < 12; i++) begin
            w = 1'($urandom_range(0, 1));
            a = (i % 4 == 3) ? 9'h1FF : 9'($urandom_range(0, 511));
            d = $urandom;
            run_access(w, a, d, i != 11, lat, wc, aok, rd, iw, to);
            if (w) model_mem[a] = d;
            else   last_read = model_mem[a];
            checks++; if (to || iw != 1 || lat != EXP_LAT) begin
                errors++; $display("FAIL b2b_period_%0d: idle_wait=%0d lat=%0d expected 1 %0d", i, iw, lat, EXP_LAT);
            end
            checks++; if (rd !== last_read || wc != (w ? 1 : 0)) begin
                errors++; $display("FAIL b2b_data_%0d: got %h wr=%0d expected %h wr=%0d", i, rd, wc, last_read, w ? 1 : 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model_mem[i] = init_word(i);
        last_read = '0;
        test_reset();
        test_write_read();
        test_boundary();
        test_busy_ignore();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
